// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared state encoding, reset pattern and saturating increment
package pattern_scan_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_REPORT = 2'd2;

  localparam logic [3:0] DEF_RST_PAT = 4'b0110;

  // Counts up by one but parks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pattern_window_match.sv
// rtl/pattern_window_match.sv - sliding match window with fill tracking and overlap control
module pattern_window_match #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic             clear,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit
);

  localparam int FW = $clog2(PAT_W + 1);

  // Only the oldest PAT_W-1 bits are stored; the newest bit arrives live on bit_in.
  logic [PAT_W-2:0] window;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] cand;

  assign cand = {window, bit_in};
  assign hit  = bit_en && (fill >= FW'(PAT_W - 1)) && (cand == pattern);

  // Advance the window on each scanned bit; a non-overlapping hit forgets history via fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      window <= '0;
      fill   <= '0;
    end else if (clear) begin
      window <= '0;
      fill   <= '0;
    end else if (bit_en) begin
      window <= cand[PAT_W-2:0];
      if (hit && !overlap) begin
        fill <= '0;
      end else if (fill != FW'(PAT_W)) begin
        fill <= fill + FW'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-in, count-out controller around the serial pattern matcher
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int               DATA_W  = 16,
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 5,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              hit,
  output logic              busy,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_count,
  input  logic              out_ready
);

  localparam int              BW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [DATA_W-1:0]  shreg;
  logic [BW-1:0]      bitcnt;
  logic [CNT_W-1:0]   count;
  logic [PAT_W-1:0]   pattern;
  logic               overlap;
  logic               accept;

  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign bit_out   = shreg[DATA_W-1];
  assign bit_valid = (state == ST_SHIFT);
  assign busy      = (state == ST_SHIFT) || (state == ST_REPORT);
  assign out_valid = (state == ST_REPORT);
  assign out_count = count;

  pattern_window_match #(
    .PAT_W(PAT_W)
  ) u_match (
    .clk    (clk),
    .rst    (rst),
    .bit_in (bit_out),
    .bit_en (bit_valid),
    .clear  (accept),
    .pattern(pattern),
    .overlap(overlap),
    .hit    (hit)
  );

  // Config only changes while idle; a write at any other time is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern <= RST_PAT;
      overlap <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state != ST_IDLE);
      if (cfg_we && (state == ST_IDLE)) begin
        pattern <= cfg_pattern;
        overlap <= cfg_overlap;
      end
    end
  end

  // Accept a word, shift it out MSB first counting hits, then hold the count until taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg  <= in_data;
            bitcnt <= '0;
            count  <= '0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg  <= shreg << 1;
          bitcnt <= bitcnt + BW'(1);
          if (hit) begin
            count <= CNT_W'(sat_inc(32'(count), 32'(CNT_MAX)));
          end
          if (bitcnt == BW'(DATA_W - 1)) begin
            state <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
